seg_mux_capture: RTL and testbench

Receive-side counterpart of the multiplexed 4-digit 7-segment drive bus. Samples the active-low anode select and the shared segment lines, and reconstructs the four per-digit segment patterns. Presents them as a coherent frame with a one-cycle frame strobe. Used for on-board loopback self-check of the alarm clock display path and as a debug monitor feeding a capture register bank.

---
 rtl/seg_pkg.sv | 59 +++++
 rtl/seg_sync2.sv | 35 +++
 rtl/seg_mux_capture.sv | 248 ++++++++++++++++++++++++
 tb/tb_seg_mux_capture.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared constants for the 7-segment capture path: active-low
//             segment glyphs, anode select patterns, capture FSM state
//             encoding and the glyph-to-decimal helper.
//  Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Active-low glyphs, bit0 = segment a .. bit6 = segment g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low anode selects
    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D3   = 4'b0111;
    localparam logic [3:0] AN_ALL  = 4'b0000;
    localparam logic [3:0] AN_NONE = 4'b1111;

    // Capture FSM: waiting for first activity, counting stability, holding
    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } seg_state_t;

    // Map an active-low glyph to its decimal value; unknown glyphs give 4'hF
    function automatic logic [3:0] seg_to_bcd(input logic [6:0] seg);
        logic [3:0] v;
        case (seg)
            SEG_0:   v = 4'd0;
            SEG_1:   v = 4'd1;
            SEG_2:   v = 4'd2;
            SEG_3:   v = 4'd3;
            SEG_4:   v = 4'd4;
            SEG_5:   v = 4'd5;
            SEG_6:   v = 4'd6;
            SEG_7:   v = 4'd7;
            SEG_8:   v = 4'd8;
            SEG_9:   v = 4'd9;
            default: v = 4'hF;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : seg_sync2
//  Purpose  : Parameterised-width two-flop synchroniser with a configurable
//             reset value, used to bring the display bus into the clk domain.
//  Revision : 1.0  initial release
// ============================================================================
module seg_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage resampling of the asynchronous bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/seg_mux_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg_mux_capture
//  Purpose  : Reconstructs the four digit patterns of a multiplexed 4-digit
//             7-segment bus. Each anode phase must be stable for
//             SETTLE_CYCLES before it is captured; a full set of four digit
//             captures is published as one frame with a frame_valid strobe.
//  Options  : SEG_MUX_CAPTURE_DECODE_EN adds bcd0..bcd3 decimal outputs.
//  Revision : 1.0  initial release
// ============================================================================
module seg_mux_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an_in,
    input  logic [6:0] num_in,
    output logic [6:0] digit0,
    output logic [6:0] digit1,
    output logic [6:0] digit2,
    output logic [6:0] digit3,
    output logic       frame_valid,
    output logic       lamp_test,
    output logic       pattern_err,
    output logic       stale
`ifdef SEG_MUX_CAPTURE_DECODE_EN
    ,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3
`endif
);

    import seg_pkg::*;

    localparam int                    c_IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0]   c_IDLE_MAX  = c_IDLE_W'(TIMEOUT_CYCLES);
    // The change cycle itself counts as the first stable cycle, so the
    // capture fires when the counter has reached SETTLE_CYCLES-1 and the
    // current sample still matches.
    localparam logic [7:0]            c_STAB_LAST = 8'(SETTLE_CYCLES - 1);

    // ---------------------------------------------------------------- input
    logic [3:0] w_an_s;
    logic [6:0] w_num_s;

    seg_sync2 #(.WIDTH(4), .RESET_VAL(AN_NONE)) u_sync_an (
        .clk   (clk),
        .reset (reset),
        .i_d   (an_in),
        .o_q   (w_an_s)
    );

    seg_sync2 #(.WIDTH(7), .RESET_VAL(SEG_BLANK)) u_sync_num (
        .clk   (clk),
        .reset (reset),
        .i_d   (num_in),
        .o_q   (w_num_s)
    );

    // ------------------------------------------------------------ registers
    seg_state_t            r_state;
    logic [7:0]            r_stab;
    logic [3:0]            r_an_prev;
    logic [6:0]            r_num_prev;
    logic [3:0]            r_seen;
    logic [3:0][6:0]       r_shadow;
    logic [3:0][6:0]       r_digit;
    logic                  r_frame_valid;
    logic                  r_pattern_err;
    logic                  r_lamp;
    logic [c_IDLE_W-1:0]   r_idle;

    // ---------------------------------------------------------- comb logic
    logic                  w_change;
    logic                  w_capture;
    logic                  w_legal;
    logic                  w_is_all;
    logic                  w_is_bad;
    logic [1:0]            w_idx;
    logic [3:0]            w_seen_set;
    logic                  w_frame_done;
    logic [3:0][6:0]       w_shadow_next;

    assign w_change  = ({w_an_s, w_num_s} != {r_an_prev, r_num_prev});
    assign w_capture = (r_state == ST_SETTLE) && !w_change && (r_stab == c_STAB_LAST);

    // Classify the synchronised anode pattern
    always_comb begin
        w_legal  = 1'b0;
        w_is_all = 1'b0;
        w_is_bad = 1'b0;
        w_idx    = 2'd0;
        case (w_an_s)
            AN_D0:   begin w_legal = 1'b1; w_idx = 2'd0; end
            AN_D1:   begin w_legal = 1'b1; w_idx = 2'd1; end
            AN_D2:   begin w_legal = 1'b1; w_idx = 2'd2; end
            AN_D3:   begin w_legal = 1'b1; w_idx = 2'd3; end
            AN_ALL:  w_is_all = 1'b1;
            AN_NONE: ;
            default: w_is_bad = 1'b1;
        endcase
    end

    assign w_seen_set   = r_seen | (4'b0001 << w_idx);
    assign w_frame_done = w_capture && w_legal && (w_seen_set == 4'hF);

    // Shadow bank as it will look after this cycle's capture, so a frame
    // completed by this capture publishes the digit being written now
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_capture && w_legal) begin
            w_shadow_next[w_idx] = w_num_s;
        end
    end

    // Stability FSM: one capture per stable phase of the synchronised bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_WAIT;
            r_stab     <= 8'd0;
            r_an_prev  <= AN_NONE;
            r_num_prev <= SEG_BLANK;
        end else begin
            r_an_prev  <= w_an_s;
            r_num_prev <= w_num_s;
            case (r_state)
                ST_WAIT: begin
                    if (w_change) begin
                        r_state <= ST_SETTLE;
                        r_stab  <= 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (w_change) begin
                        r_stab <= 8'd1;
                    end else if (r_stab == c_STAB_LAST) begin
                        r_state <= ST_HELD;
                    end else begin
                        r_stab <= r_stab + 8'd1;
                    end
                end
                ST_HELD: begin
                    if (w_change) begin
                        r_state <= ST_SETTLE;
                        r_stab  <= 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_WAIT;
                    r_stab  <= 8'd0;
                end
            endcase
        end
    end

    // Capture datapath: shadow bank, seen mask, frame publication and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow      <= {4{SEG_BLANK}};
            r_digit       <= {4{SEG_BLANK}};
            r_seen        <= 4'h0;
            r_frame_valid <= 1'b0;
            r_pattern_err <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_pattern_err <= 1'b0;
            if (w_capture) begin
                if (w_legal) begin
                    r_shadow <= w_shadow_next;
                    if (w_frame_done) begin
                        r_digit       <= w_shadow_next;
                        r_frame_valid <= 1'b1;
                        r_seen        <= 4'h0;
                    end else begin
                        r_seen <= w_seen_set;
                    end
                end else if (w_is_all) begin
                    // All anodes lit: restart the frame, keep shadow contents
                    r_seen <= 4'h0;
                end else if (w_is_bad) begin
                    r_pattern_err <= 1'b1;
                end
            end
        end
    end

    // Lamp-test flag follows the synchronised anodes without settling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lamp <= 1'b0;
        end else begin
            r_lamp <= (w_an_s == AN_ALL);
        end
    end

    // Saturating idle counter, cleared by any capture event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
        end else if (w_capture) begin
            r_idle <= '0;
        end else if (r_idle != c_IDLE_MAX) begin
            r_idle <= r_idle + 1'b1;
        end
    end

`ifdef SEG_MUX_CAPTURE_DECODE_EN
    logic [3:0] r_bcd0;
    logic [3:0] r_bcd1;
    logic [3:0] r_bcd2;
    logic [3:0] r_bcd3;

    // Decimal view of the frame, updated together with the digit outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd0 <= 4'hF;
            r_bcd1 <= 4'hF;
            r_bcd2 <= 4'hF;
            r_bcd3 <= 4'hF;
        end else if (w_frame_done) begin
            r_bcd0 <= seg_to_bcd(w_shadow_next[0]);
            r_bcd1 <= seg_to_bcd(w_shadow_next[1]);
            r_bcd2 <= seg_to_bcd(w_shadow_next[2]);
            r_bcd3 <= seg_to_bcd(w_shadow_next[3]);
        end
    end

    assign bcd0 = r_bcd0;
    assign bcd1 = r_bcd1;
    assign bcd2 = r_bcd2;
    assign bcd3 = r_bcd3;
`endif

    // ------------------------------------------------------------- outputs
    assign digit0      = r_digit[0];
    assign digit1      = r_digit[1];
    assign digit2      = r_digit[2];
    assign digit3      = r_digit[3];
    assign frame_valid = r_frame_valid;
    assign pattern_err = r_pattern_err;
    assign lamp_test   = r_lamp;
    assign stale       = (r_idle == c_IDLE_MAX);

endmodule
`default_nettype wire

// File: tb/tb_seg_mux_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_mux_capture
//  Purpose  : Directed, table-driven self-check of seg_mux_capture with
//             SETTLE_CYCLES=4 and a short TIMEOUT_CYCLES.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg_mux_capture;

    localparam int SETTLE = 4;
    localparam int TMO    = 64;
    localparam int SPLIT  = 10;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] an_in  = 4'hF;
    logic [6:0] num_in = 7'h7F;
    logic [6:0] digit0, digit1, digit2, digit3;
    logic       frame_valid, lamp_test, pattern_err, stale;
`ifdef SEG_MUX_CAPTURE_DECODE_EN
    logic [3:0] bcd0, bcd1, bcd2, bcd3;
`endif

    always #5 clk = ~clk;

    seg_mux_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .an_in       (an_in),
        .num_in      (num_in),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .frame_valid (frame_valid),
        .lamp_test   (lamp_test),
        .pattern_err (pattern_err),
        .stale       (stale)
`ifdef SEG_MUX_CAPTURE_DECODE_EN
        ,
        .bcd0        (bcd0),
        .bcd1        (bcd1),
        .bcd2        (bcd2),
        .bcd3        (bcd3)
`endif
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] num;
        int         hold;
        bit         rst;
        int         fv;
        int         pe;
        logic [27:0] dig;
    } vec_t;

    vec_t       vecs[$];
    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         fv_cnt = 0;
    int         pe_cnt = 0;
    logic [3:0] prev_an = 4'hF;

    // Pulse counters sampled just after each active edge
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            fv_cnt += int'(frame_valid);
            pe_cnt += int'(pattern_err);
        end
    end

    function automatic vec_t mk(input logic [3:0] an, input logic [6:0] num, input int hold,
                                input bit rst, input int fv, input int pe, input logic [27:0] dig);
        vec_t v;
        v.an = an; v.num = num; v.hold = hold; v.rst = rst;
        v.fv = fv; v.pe = pe; v.dig = dig;
        return v;
    endfunction

    function automatic logic [3:0] exp_bcd(input logic [6:0] s);
        case (s)
            7'h40: return 4'd0;
            7'h79: return 4'd1;
            7'h24: return 4'd2;
            7'h30: return 4'd3;
            7'h19: return 4'd4;
            7'h12: return 4'd5;
            7'h02: return 4'd6;
            7'h78: return 4'd7;
            7'h00: return 4'd8;
            7'h10: return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        int fv0;
        int pe0;
        if (v.rst) begin
            an_in  = 4'hF;
            num_in = 7'h7F;
            reset  = 1'b1;
            #1;
            check($sformatf("v%0d_async_reset", idx),
                  {digit0, digit1, digit2, digit3, frame_valid, lamp_test, pattern_err, stale},
                  32'hFFFFFFF0);
            repeat (2) @(negedge clk);
            reset   = 1'b0;
            prev_an = 4'hF;
        end
        fv0    = fv_cnt;
        pe0    = pe_cnt;
        an_in  = v.an;
        num_in = v.num;
        for (int c = 1; c <= v.hold; c++) begin
            @(negedge clk);
            if (c == 2) check($sformatf("v%0d_lamp_old", idx), 32'(lamp_test), 32'(prev_an == 4'h0));
            if (c == 3) check($sformatf("v%0d_lamp_new", idx), 32'(lamp_test), 32'(v.an == 4'h0));
        end
        check($sformatf("v%0d_frame_valid_pulses", idx), 32'(fv_cnt - fv0), 32'(v.fv));
        check($sformatf("v%0d_pattern_err_pulses", idx), 32'(pe_cnt - pe0), 32'(v.pe));
        check($sformatf("v%0d_digits", idx), 32'({digit0, digit1, digit2, digit3}), 32'(v.dig));
`ifdef SEG_MUX_CAPTURE_DECODE_EN
        check($sformatf("v%0d_bcd", idx), 32'({bcd0, bcd1, bcd2, bcd3}),
              32'({exp_bcd(v.dig[27:21]), exp_bcd(v.dig[20:14]), exp_bcd(v.dig[13:7]), exp_bcd(v.dig[6:0])}));
`endif
        prev_an = v.an;
    endtask

    initial begin
        // Expected digits listed as {digit0, digit1, digit2, digit3}
        // Basic frame 1,2,3,4 then an idle phase
        vecs.push_back(mk(4'hE, 7'h79, 8, 0, 0, 0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}));
        vecs.push_back(mk(4'hD, 7'h24, 8, 0, 0, 0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}));
        vecs.push_back(mk(4'hB, 7'h30, 8, 0, 0, 0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}));
        vecs.push_back(mk(4'h7, 7'h19, 8, 0, 1, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'hF, 7'h7F, 8, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        // Phases shorter than the settle time never capture
        vecs.push_back(mk(4'hE, 7'h12, 3, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'hD, 7'h02, 3, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'hB, 7'h12, 3, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'h7, 7'h02, 3, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'hF, 7'h7F, 3, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        // Lamp test restarts the frame after digits 0,1
        vecs.push_back(mk(4'hE, 7'h40, 8, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'hD, 7'h79, 8, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'h0, 7'h7F, 8, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'hB, 7'h24, 8, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'h7, 7'h30, 8, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'hE, 7'h00, 8, 0, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}));
        vecs.push_back(mk(4'hD, 7'h10, 8, 0, 1, 0, {7'h00, 7'h10, 7'h24, 7'h30}));
        // Illegal anode pattern
        vecs.push_back(mk(4'h9, 7'h7F, 8, 0, 0, 1, {7'h00, 7'h10, 7'h24, 7'h30}));
        vecs.push_back(mk(4'hF, 7'h7F, 8, 0, 0, 0, {7'h00, 7'h10, 7'h24, 7'h30}));
        // Segment lines toggling inside the digit2 phase, then SEG_7 held
        vecs.push_back(mk(4'hB, 7'h12, 2, 0, 0, 0, {7'h00, 7'h10, 7'h24, 7'h30}));
        vecs.push_back(mk(4'hB, 7'h02, 2, 0, 0, 0, {7'h00, 7'h10, 7'h24, 7'h30}));
        vecs.push_back(mk(4'hB, 7'h12, 2, 0, 0, 0, {7'h00, 7'h10, 7'h24, 7'h30}));
        vecs.push_back(mk(4'hB, 7'h02, 2, 0, 0, 0, {7'h00, 7'h10, 7'h24, 7'h30}));
        vecs.push_back(mk(4'hB, 7'h78, 8, 0, 0, 0, {7'h00, 7'h10, 7'h24, 7'h30}));
        vecs.push_back(mk(4'hE, 7'h79, 8, 0, 0, 0, {7'h00, 7'h10, 7'h24, 7'h30}));
        vecs.push_back(mk(4'hD, 7'h24, 8, 0, 0, 0, {7'h00, 7'h10, 7'h24, 7'h30}));
        vecs.push_back(mk(4'h7, 7'h30, 8, 0, 1, 0, {7'h79, 7'h24, 7'h78, 7'h30}));
        // Three digits captured, then reset discards the partial frame
        vecs.push_back(mk(4'hE, 7'h10, 8, 0, 0, 0, {7'h79, 7'h24, 7'h78, 7'h30}));
        vecs.push_back(mk(4'hD, 7'h00, 8, 0, 0, 0, {7'h79, 7'h24, 7'h78, 7'h30}));
        vecs.push_back(mk(4'hB, 7'h40, 8, 0, 0, 0, {7'h79, 7'h24, 7'h78, 7'h30}));
        vecs.push_back(mk(4'hE, 7'h79, 8, 1, 0, 0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}));
        vecs.push_back(mk(4'hD, 7'h24, 8, 0, 0, 0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}));
        vecs.push_back(mk(4'hB, 7'h30, 8, 0, 0, 0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}));
        vecs.push_back(mk(4'h7, 7'h19, 8, 0, 1, 0, {7'h79, 7'h24, 7'h30, 7'h19}));

        repeat (3) @(negedge clk);
        check("reset_state",
              {digit0, digit1, digit2, digit3, frame_valid, lamp_test, pattern_err, stale},
              32'hFFFFFFF0);
`ifdef SEG_MUX_CAPTURE_DECODE_EN
        check("reset_bcd", 32'({bcd0, bcd1, bcd2, bcd3}), 32'hFFFF);
`endif
        reset = 1'b0;

        // Vectors 0..8: the last vector before SPLIT is the short idle phase
        for (int i = 0; i < SPLIT - 1; i++) apply(vecs[i], i);

        // Stale: the idle capture of vector 4 was the last capture; the short
        // phases and these toggles keep the bus moving without settling.
        check("stale_before_toggle", 32'(stale), 32'd0);
        for (int p = 0; p < 19; p++) begin
            an_in  = (p % 2 == 0) ? 4'hE : 4'hD;
            num_in = 7'h7F;
            repeat (3) @(negedge clk);
            if (p == 12) check("stale_below_timeout", 32'(stale), 32'd0);
        end
        check("stale_after_timeout", 32'(stale), 32'd1);
        check("stale_keeps_digits", 32'({digit0, digit1, digit2, digit3}),
              32'({7'h79, 7'h24, 7'h30, 7'h19}));
        an_in  = 4'hF;
        num_in = 7'h7F;
        repeat (8) @(negedge clk);
        check("stale_cleared_by_capture", 32'(stale), 32'd0);
        prev_an = 4'hF;

        for (int i = SPLIT; i < vecs.size(); i++) apply(vecs[i], i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
